// File: rtl/sw_debounce_combiner.sv
// Switch front end: per-channel 2-flop synchroniser, debounce, press pulse and a combined LED.
// Optional press counters on PCNT are built when SW_PRESS_CNT_EN is defined.
module sw_debounce_combiner #(
  parameter int N       = 2,
  parameter int CNT_W   = 16,
  parameter int DEB_MAX = 50000,
  parameter int MODE    = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] SW,
  output logic [N-1:0] LED,
  output logic [N-1:0] PRESS,
  output logic         LED0
`ifdef SW_PRESS_CNT_EN
  ,
  output logic [8*N-1:0] PCNT
`endif
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N-1:0]     sync1_r;
  logic [N-1:0]     sync2_r;
  logic [CNT_W-1:0] cnt_r     [N];
  logic [CNT_W-1:0] cnt_nxt_s [N];
  logic [N-1:0]     pressed_s;
  logic [N-1:0]     accept_s;

  // Reduction selected by MODE; unknown modes fall back to AND.
  function automatic logic combine(input logic [N-1:0] v);
    case (MODE)
      32'd1:   return |v;
      32'd2:   return ^v;
      default: return &v;
    endcase
  endfunction

  // Debounce next-state: a change is accepted only after DEB_MAX stable mismatching samples.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pressed_s[i] = ~sync2_r[i];
      if (pressed_s[i] == LED[i]) begin
        cnt_nxt_s[i] = '0;
        accept_s[i]  = 1'b0;
      end else if (cnt_r[i] == DEB_LAST) begin
        cnt_nxt_s[i] = '0;
        accept_s[i]  = 1'b1;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        accept_s[i]  = 1'b0;
      end
    end
  end

  // Synchronisers, debounce state, press pulses and optional press counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_r <= '1;
      sync2_r <= '1;
      LED     <= '0;
      PRESS   <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= '0;
      end
`ifdef SW_PRESS_CNT_EN
      PCNT    <= '0;
`endif
    end else begin
      sync1_r <= SW;
      sync2_r <= sync1_r;
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
        // Accepting a change with pressed_s high is by construction a 0->1 transition.
        PRESS[i] <= accept_s[i] & pressed_s[i];
        if (accept_s[i]) begin
          LED[i] <= pressed_s[i];
        end
`ifdef SW_PRESS_CNT_EN
        if (accept_s[i] & pressed_s[i]) begin
          PCNT[8*i +: 8] <= PCNT[8*i +: 8] + 8'd1;
        end
`endif
      end
    end
  end

  // Combined indicator, one cycle behind LED.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LED0 <= 1'b0;
    end else begin
      LED0 <= combine(LED);
    end
  end

endmodule

// File: tb/tb_sw_debounce_combiner.sv
// Directed bench for sw_debounce_combiner: N=2, DEB_MAX=4, one instance per MODE plus a DEB_MAX=1 instance.
module tb_sw_debounce_combiner;

  logic       CLK;
  logic       RST;
  logic [1:0] SW;

  logic [1:0] led_m0, led_m1, led_m2, led_m3, led_d1;
  logic [1:0] press_m0, press_m1, press_m2, press_m3, press_d1;
  logic       led0_m0, led0_m1, led0_m2, led0_m3, led0_d1;
`ifdef SW_PRESS_CNT_EN
  logic [15:0] pcnt_m0, pcnt_m1, pcnt_m2, pcnt_m3, pcnt_d1;
`endif

  int n_checks = 0;
  int n_errors = 0;

`ifdef SW_PRESS_CNT_EN
  sw_debounce_combiner #(.N(2), .CNT_W(16), .DEB_MAX(4), .MODE(0)) u_m0 (.CLK(CLK), .RST(RST), .SW(SW), .LED(led_m0), .PRESS(press_m0), .LED0(led0_m0), .PCNT(pcnt_m0));
  sw_debounce_combiner #(.N(2), .CNT_W(16), .DEB_MAX(4), .MODE(1)) u_m1 (.CLK(CLK), .RST(RST), .SW(SW), .LED(led_m1), .PRESS(press_m1), .LED0(led0_m1), .PCNT(pcnt_m1));
  sw_debounce_combiner #(.N(2), .CNT_W(16), .DEB_MAX(4), .MODE(2)) u_m2 (.CLK(CLK), .RST(RST), .SW(SW), .LED(led_m2), .PRESS(press_m2), .LED0(led0_m2), .PCNT(pcnt_m2));
  sw_debounce_combiner #(.N(2), .CNT_W(16), .DEB_MAX(4), .MODE(3)) u_m3 (.CLK(CLK), .RST(RST), .SW(SW), .LED(led_m3), .PRESS(press_m3), .LED0(led0_m3), .PCNT(pcnt_m3));
  sw_debounce_combiner #(.N(2), .CNT_W(16), .DEB_MAX(1), .MODE(0)) u_d1 (.CLK(CLK), .RST(RST), .SW(SW), .LED(led_d1), .PRESS(press_d1), .LED0(led0_d1), .PCNT(pcnt_d1));
`else
  sw_debounce_combiner #(.N(2), .CNT_W(16), .DEB_MAX(4), .MODE(0)) u_m0 (.CLK(CLK), .RST(RST), .SW(SW), .LED(led_m0), .PRESS(press_m0), .LED0(led0_m0));
  sw_debounce_combiner #(.N(2), .CNT_W(16), .DEB_MAX(4), .MODE(1)) u_m1 (.CLK(CLK), .RST(RST), .SW(SW), .LED(led_m1), .PRESS(press_m1), .LED0(led0_m1));
  sw_debounce_combiner #(.N(2), .CNT_W(16), .DEB_MAX(4), .MODE(2)) u_m2 (.CLK(CLK), .RST(RST), .SW(SW), .LED(led_m2), .PRESS(press_m2), .LED0(led0_m2));
  sw_debounce_combiner #(.N(2), .CNT_W(16), .DEB_MAX(4), .MODE(3)) u_m3 (.CLK(CLK), .RST(RST), .SW(SW), .LED(led_m3), .PRESS(press_m3), .LED0(led0_m3));
  sw_debounce_combiner #(.N(2), .CNT_W(16), .DEB_MAX(1), .MODE(0)) u_d1 (.CLK(CLK), .RST(RST), .SW(SW), .LED(led_d1), .PRESS(press_d1), .LED0(led0_d1));
`endif

  // Free-running clock, first rising edge at t=5.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RST = 1'b0;
    SW  = 2'b11;

    // Reset clears outputs before any clock edge.
    #2 RST = 1'b1;
    #1;
    chk("rst_led_async",   {30'd0, led_m0},   32'd0);
    chk("rst_press_async", {30'd0, press_m0}, 32'd0);
    chk("rst_led0_async",  {31'd0, led0_m0},  32'd0);
`ifdef SW_PRESS_CNT_EN
    chk("rst_pcnt_async",  {16'd0, pcnt_m0},  32'd0);
`endif
    tick(3);
    RST = 1'b0;
    tick(2);
    chk("rst_led_hold",   {30'd0, led_m0},   32'd0);
    chk("rst_press_hold", {30'd0, press_m0}, 32'd0);
    chk("rst_led0_hold",  {31'd0, led0_m1},  32'd0);

    // Clean press on channel 0.
    SW = 2'b10;
    tick(2);
    chk("d1_led_e2", {30'd0, led_d1}, 32'd0);
    tick(1);
    chk("d1_led_e3",   {30'd0, led_d1},   32'd1);
    chk("d1_press_e3", {30'd0, press_d1}, 32'd1);
    chk("led_e3",      {30'd0, led_m0},   32'd0);
    tick(2);
    chk("led_e5",   {30'd0, led_m0},   32'd0);
    chk("press_e5", {30'd0, press_m0}, 32'd0);
    tick(1);
    chk("led_e6",     {30'd0, led_m0},   32'd1);
    chk("press_e6",   {30'd0, press_m0}, 32'd1);
    chk("or_led0_e6", {31'd0, led0_m1},  32'd0);
    tick(1);
    chk("press_e7",    {30'd0, press_m0}, 32'd0);
    chk("led_e7",      {30'd0, led_m0},   32'd1);
    chk("and_led0_e7", {31'd0, led0_m0},  32'd0);
    chk("or_led0_e7",  {31'd0, led0_m1},  32'd1);
    chk("xor_led0_e7", {31'd0, led0_m2},  32'd1);
    chk("m3_led0_e7",  {31'd0, led0_m3},  32'd0);

    // Glitch: channel 1 low for 3 cycles is one sample short of acceptance.
    SW = 2'b00;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) SW = 2'b10;
      tick(1);
      chk("glitch_led",   {30'd0, led_m0},   32'd1);
      chk("glitch_press", {30'd0, press_m0}, 32'd0);
      chk("glitch_led0",  {31'd0, led0_m0},  32'd0);
    end

    // Combine: both pressed.
    SW = 2'b00;
    tick(5);
    chk("both_led_e5", {30'd0, led_m0}, 32'd1);
    tick(1);
    chk("both_led_e6",   {30'd0, led_m0},   32'd3);
    chk("both_press_e6", {30'd0, press_m0}, 32'd2);
    chk("both_and_e6",   {31'd0, led0_m0},  32'd0);
    tick(1);
    chk("both_press_e7", {30'd0, press_m0}, 32'd0);
    chk("both_and_e7",   {31'd0, led0_m0},  32'd1);
    chk("both_or_e7",    {31'd0, led0_m1},  32'd1);
    chk("both_xor_e7",   {31'd0, led0_m2},  32'd0);
    chk("both_m3_e7",    {31'd0, led0_m3},  32'd1);

    // Release both: no pulse on release.
    SW = 2'b11;
    tick(5);
    chk("rel_led_e5", {30'd0, led_m0}, 32'd3);
    tick(1);
    chk("rel_led_e6",   {30'd0, led_m0},   32'd0);
    chk("rel_press_e6", {30'd0, press_m0}, 32'd0);
    tick(2);
    chk("rel_and_led0", {31'd0, led0_m0}, 32'd0);
    chk("rel_or_led0",  {31'd0, led0_m1}, 32'd0);

    // Reset mid-count discards the partial count.
    SW = 2'b10;
    tick(3);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("mid_led_rst",   {30'd0, led_m0},   32'd0);
    chk("mid_press_rst", {30'd0, press_m0}, 32'd0);
    tick(5);
    chk("mid_led_e5",   {30'd0, led_m0},   32'd0);
    chk("mid_press_e5", {30'd0, press_m0}, 32'd0);
    tick(1);
    chk("mid_led_e6",   {30'd0, led_m0},   32'd1);
    chk("mid_press_e6", {30'd0, press_m0}, 32'd1);

`ifdef SW_PRESS_CNT_EN
    tick(1);
    chk("pcnt_one", {16'd0, pcnt_m0}, 32'h0001);
    // 257 press/release pairs on channel 0 from a clean reset wrap to 1.
    SW  = 2'b11;
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("pcnt_rst", {16'd0, pcnt_m0}, 32'h0000);
    for (int k = 0; k < 257; k++) begin
      SW = 2'b10;
      tick(7);
      SW = 2'b11;
      tick(7);
    end
    chk("pcnt_wrap", {16'd0, pcnt_m0}, 32'h0001);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
